// File: rtl/instruction_sequencer.sv
// Instruction step sequencer: fetches an instruction word with a ready handshake,
// latches it, and walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for control_matrix.
module instruction_sequencer #(
    parameter int         INSTR_WIDTH = 16,
    parameter logic [3:0] LOAD_OP     = 4'h4,
    parameter logic [3:0] STORE_OP    = 4'h5,
    parameter logic [3:0] BRANCH_OP   = 4'h8,
    parameter logic [3:0] HALT_OP     = 4'hF,
    parameter int         TIMEOUT     = 15,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   control_reset_n,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    input  logic                   mem_ready,
    input  logic                   state_machine_reset,
    input  logic                   resume,
    output logic [2:0]             state,
    output logic [3:0]             opcode,
    output logic [INSTR_WIDTH-5:0] operand,
    output logic                   fetch_req,
    output logic                   mem_req,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);

    state_t                   state_q, state_d;
    logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
    logic [7:0]               wait_q, wait_d;
    logic                     fault_q, fault_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     retire;
    logic [8:0]               wait_next;
    logic [3:0]               op;

    assign op = ir_q[INSTR_WIDTH-1 -: 4];

    always_ff @(posedge clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        count_d   = count_q;
        retire    = 1'b0;
        wait_next = {1'b0, wait_q} + 9'd1;

        // A restart request from control_matrix beats everything except a halted core.
        if (state_machine_reset && (state_q != S_HALT)) begin
            state_d = S_FETCH;
            wait_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_d    = instr_data;
                        state_d = S_DECODE;
                        wait_d  = '0;
                    end else if (wait_next >= TIMEOUT_L) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_next[7:0];
                    end
                end
                S_DECODE: begin
                    if (op == HALT_OP) begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if ((op == LOAD_OP) || (op == STORE_OP)) begin
                        state_d = S_MEMORY;
                        wait_d  = '0;
                    end else if (op == BRANCH_OP) begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        wait_d = '0;
                        if (op == LOAD_OP) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end else if (wait_next >= TIMEOUT_L) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_next[7:0];
                    end
                end
                S_WRITEBACK: begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                    retire  = 1'b1;
                end
                S_HALT: begin
                    // A fault is only cleared by reset, so resume cannot escape it.
                    if (resume && !fault_q) begin
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    wait_d  = '0;
                end
            endcase
        end

        if (retire) begin
            count_d = count_q + 1'b1;
        end
    end

    assign state       = state_q;
    assign opcode      = op;
    assign operand     = ir_q[INSTR_WIDTH-5:0];
    assign fetch_req   = (state_q == S_FETCH);
    assign mem_req     = (state_q == S_MEMORY);
    assign halted      = (state_q == S_HALT);
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_instruction_sequencer;

    localparam int TMO = 15;
    localparam int CW  = 8;

    logic          clock;
    logic          control_reset_n;
    logic [15:0]   instr_data;
    logic          mem_ready;
    logic          state_machine_reset;
    logic          resume;
    logic [2:0]    state;
    logic [3:0]    opcode;
    logic [11:0]   operand;
    logic          fetch_req;
    logic          mem_req;
    logic          halted;
    logic          fault;
    logic [CW-1:0] instr_count;

    instruction_sequencer #(
        .INSTR_WIDTH (16),
        .TIMEOUT     (TMO),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock               (clock),
        .control_reset_n     (control_reset_n),
        .instr_data          (instr_data),
        .mem_ready           (mem_ready),
        .state_machine_reset (state_machine_reset),
        .resume              (resume),
        .state               (state),
        .opcode              (opcode),
        .operand             (operand),
        .fetch_req           (fetch_req),
        .mem_req             (mem_req),
        .halted              (halted),
        .fault               (fault),
        .instr_count         (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural view only (latched word, retired count, sticky fault).
    logic [15:0] m_ir;
    int          m_count;
    logic        m_fault;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Check all outputs for the current cycle, then drive this cycle's inputs.
    task automatic cyc(input logic [2:0] es, input logic mr,
                       input logic rs = 1'b0, input logic smr = 1'b0);
        chk("state", 32'(state), 32'(es));
        chk("fetch_req", 32'(fetch_req), 32'(es == 3'd1));
        chk("mem_req", 32'(mem_req), 32'(es == 3'd4));
        chk("halted", 32'(halted), 32'(es == 3'd7));
        chk("opcode", 32'(opcode), 32'(m_ir[15:12]));
        chk("operand", 32'(operand), 32'(m_ir[11:0]));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("instr_count", 32'(instr_count), 32'(m_count % (1 << CW)));
        mem_ready           = mr;
        resume              = rs;
        state_machine_reset = smr;
        @(negedge clock);
    endtask

    task automatic do_reset();
        control_reset_n = 1'b0;
        #2;
        m_ir    = '0;
        m_count = 0;
        m_fault = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(negedge clock);
        control_reset_n     = 1'b1;
        mem_ready           = 1'b0;
        resume              = 1'b0;
        state_machine_reset = 1'b0;
    endtask

    // One instruction from its first FETCH cycle. df/dm = cycles mem_ready stays low
    // in FETCH/MEMORY. status: 0 back in FETCH, 1 halted by HALT_OP, 2 faulted.
    task automatic run_instr(input logic [15:0] ins, input int df, input int dm, output int status);
        logic [3:0] op;
        op = ins[15:12];
        if (df >= TMO) begin
            for (int i = 0; i < TMO; i++) begin
                instr_data = 16'($urandom);
                cyc(3'd1, 1'b0);
            end
            m_fault = 1'b1;
            status  = 2;
            return;
        end
        for (int i = 0; i < df; i++) begin
            instr_data = 16'($urandom);
            cyc(3'd1, 1'b0);
        end
        instr_data = ins;
        cyc(3'd1, 1'b1);
        m_ir       = ins;
        instr_data = 16'($urandom);
        cyc(3'd2, 1'($urandom));
        if (op == 4'hF) begin
            m_count++;
            status = 1;
            return;
        end
        cyc(3'd3, 1'($urandom));
        if (op == 4'h8) begin
            m_count++;
            status = 0;
            return;
        end
        if ((op == 4'h4) || (op == 4'h5)) begin
            if (dm >= TMO) begin
                for (int i = 0; i < TMO; i++) cyc(3'd4, 1'b0);
                m_fault = 1'b1;
                status  = 2;
                return;
            end
            for (int i = 0; i < dm; i++) cyc(3'd4, 1'b0);
            cyc(3'd4, 1'b1);
            if (op == 4'h5) begin
                m_count++;
                status = 0;
                return;
            end
        end
        cyc(3'd5, 1'($urandom));
        m_count++;
        status = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [15:0] ins;
        int k, df, dm;
        checks              = 0;
        errors              = 0;
        m_ir                = '0;
        m_count             = 0;
        m_fault             = 1'b0;
        control_reset_n     = 1'b0;
        instr_data          = '0;
        mem_ready           = 1'b0;
        state_machine_reset = 1'b0;
        resume              = 1'b0;
        repeat (2) @(negedge clock);

        // Basic ALU-class instruction, then load with memory wait, then store.
        do_reset();
        cyc(3'd0, 1'b1);
        run_instr(16'h1234, 0, 0, st);
        run_instr(16'h4abc, 0, 3, st);
        run_instr(16'h5abc, 0, 0, st);

        // Fetch timeout: fault is sticky and resume cannot leave HALT.
        run_instr(16'h1111, TMO, 0, st);
        cyc(3'd7, 1'b0, 1'b1);
        cyc(3'd7, 1'b0);
        do_reset();
        cyc(3'd0, 1'b0);

        // HALT_OP retires, resume restarts fetching.
        run_instr(16'hF000, 0, 0, st);
        cyc(3'd7, 1'b0);
        cyc(3'd7, 1'b0, 1'b1);

        // mem_ready on the last allowed wait cycle still advances normally.
        run_instr(16'h1234, TMO - 1, 0, st);
        run_instr(16'h4777, 0, TMO - 1, st);

        // Restart request in EXECUTE overrides mem_ready; IR and count untouched.
        instr_data = 16'h2111;
        cyc(3'd1, 1'b1);
        m_ir = 16'h2111;
        cyc(3'd2, 1'b0);
        cyc(3'd3, 1'b1, 1'b0, 1'b1);
        run_instr(16'h8000, 0, 0, st);

        // Restart request is ignored in HALT.
        run_instr(16'hF0F0, 0, 0, st);
        cyc(3'd7, 1'b0, 1'b0, 1'b1);
        cyc(3'd7, 1'b0, 1'b1, 1'b0);

        // Memory-phase timeout.
        run_instr(16'h4111, 0, TMO + 5, st);
        cyc(3'd7, 1'b0, 1'b1);
        do_reset();
        cyc(3'd0, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            ins = 16'($urandom);
            if (k <= 2)      ins[15:12] = 4'h4;
            else if (k <= 4) ins[15:12] = 4'h5;
            else if (k <= 6) ins[15:12] = 4'h8;
            else if (k == 7) ins[15:12] = 4'hF;
            else             ins[15:12] = 4'($urandom_range(0, 14));
            df = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 4);
            dm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 4);
            run_instr(ins, df, dm, st);
            if (st == 1) begin
                cyc(3'd7, 1'b0);
                cyc(3'd7, 1'b0, 1'b1);
            end else if (st == 2) begin
                cyc(3'd7, 1'b0, 1'b1);
                do_reset();
                cyc(3'd0, 1'b0);
            end
        end

        // Reset in the middle of a fetch wait leaves no trace.
        for (int i = 0; i < 5; i++) cyc(3'd1, 1'b0);
        do_reset();
        cyc(3'd0, 1'b0);

        // Retired-instruction counter wraps.
        while ((m_count % (1 << CW)) != ((1 << CW) - 1)) run_instr(16'h8123, 0, 0, st);
        run_instr(16'h8123, 0, 0, st);
        chk("count_wrap", 32'(instr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
